// File: rtl/vote_sample_ctrl_if.sv
// ============================================================================
//  Module      : vote_sample_ctrl_if
//  Description : Valid/ready result channel carrying the voted bit from the
//                vote sequencer to its consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vote_sample_ctrl_if;
  logic out_val;
  logic out_bit;
  logic out_rdy;

  modport master (
    output out_val,
    output out_bit,
    input  out_rdy
  );

  modport slave (
    input  out_val,
    input  out_bit,
    output out_rdy
  );
endinterface

`default_nettype wire

// File: rtl/vote_sample_ctrl.sv
// ============================================================================
//  Module      : vote_sample_ctrl
//  Description : Takes three spaced samples of a noisy input, emits the 2-of-3
//                majority over a valid/ready channel. Optional macro
//                DISAGREE_CNT_EN adds o_unan and a saturating o_err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vote_sample_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [DIV_W-1:0]   i_div,
  input  logic               i_sig_in,
  output logic               o_busy,
  vote_sample_ctrl_if.master o_vote
`ifdef DISAGREE_CNT_EN
  ,
  output logic               o_unan,
  output logic [7:0]         o_err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [1:0]       r_s;
  logic             r_out_val;
  logic             r_out_bit;
  logic             w_maj;
  logic             w_hshk;

  // Third sample is never stored: it is voted directly as it arrives.
  assign w_maj = (r_s[0] & r_s[1]) | ((r_s[0] | r_s[1]) & i_sig_in);

  always_comb begin
    w_state_nxt = r_state;
    w_hshk      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_WAIT;
      S_WAIT: if ((r_cnt == '0) && (r_idx == 2'd2)) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (o_vote.out_rdy) begin
          w_state_nxt = S_IDLE;
          w_hshk      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div_q   <= '0;
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_s       <= 2'b00;
      r_out_val <= 1'b0;
      r_out_bit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_div_q <= i_div;
            r_cnt   <= i_div;
            r_idx   <= 2'd0;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt <= r_div_q;
            if (r_idx == 2'd2) begin
              r_out_bit <= w_maj;
              r_out_val <= 1'b1;
            end else begin
              r_s[r_idx[0]] <= i_sig_in;
              r_idx         <= r_idx + 2'd1;
            end
          end
        end
        S_HOLD: if (w_hshk) r_out_val <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_vote.out_val = r_out_val;
  assign o_vote.out_bit = r_out_bit;

`ifdef DISAGREE_CNT_EN
  logic       r_unan;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unan    <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if ((r_state == S_WAIT) && (r_cnt == '0) && (r_idx == 2'd2))
        r_unan <= (r_s[0] == r_s[1]) && (r_s[1] == i_sig_in);
      if (w_hshk && !r_unan && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_unan    = r_unan;
  assign o_err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vote_sample_ctrl.sv
// ============================================================================
//  Module      : tb_vote_sample_ctrl
//  Description : Self-checking bench for vote_sample_ctrl (table + sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vote_sample_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_div;
  logic       i_sig_in;
  logic       o_busy;
`ifdef DISAGREE_CNT_EN
  logic       o_unan;
  logic [7:0] o_err_cnt;
  int         err_m;
`endif

  int checks;
  int failures;
  logic sb_q[$];

  typedef struct {
    int       div;
    int       div_after;
    logic [2:0] s;
    int       rdy_delay;
    bit       hold_start;
    logic     exp;
  } vec_t;

  vec_t tbl[9];

  vote_sample_ctrl_if u_if ();

  vote_sample_ctrl #(.DIV_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_div    (i_div),
    .i_sig_in (i_sig_in),
    .o_busy   (o_busy),
    .o_vote   (u_if)
`ifdef DISAGREE_CNT_EN
    ,
    .o_unan    (o_unan),
    .o_err_cnt (o_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vote(input vec_t v);
    int   sp;
    bit   early;
    bit   stable;
    logic b0;
    logic e;
    sp = v.div + 1;
    sb_q.push_back(v.exp);
    u_if.out_rdy = 1'b0;
    i_div        = v.div[7:0];
    i_start      = 1'b1;
    i_sig_in     = ~v.s[0];
    @(posedge clk); #1;
    i_start = 1'b0;
    i_div   = v.div_after[7:0];
    chk("busy_after_start", o_busy, 1);
    early = 1'b0;
    for (int c = 1; c <= 3 * sp; c++) begin
      if (u_if.out_val) early = 1'b1;
      // Only the sampling cycle carries the wanted value; others carry its inverse.
      i_sig_in = (c % sp == 0) ? v.s[c / sp - 1] : ~v.s[(c - 1) / sp];
      @(posedge clk); #1;
    end
    chk("no_early_valid", early, 0);
    chk("out_val_at_latency", u_if.out_val, 1);
    e = sb_q.pop_front();
    chk("out_bit", u_if.out_bit, e);
`ifdef DISAGREE_CNT_EN
    chk("unan", o_unan, (v.s == 3'b000) || (v.s == 3'b111));
`endif
    b0      = u_if.out_bit;
    stable  = 1'b1;
    i_start = v.hold_start;
    for (int d = 0; d < v.rdy_delay; d++) begin
      @(posedge clk); #1;
      if (!u_if.out_val || (u_if.out_bit !== b0) || !o_busy) stable = 1'b0;
    end
    if (v.rdy_delay > 0) chk("hold_stable", stable, 1);
    u_if.out_rdy = 1'b1;
    @(posedge clk); #1;
    u_if.out_rdy = 1'b0;
    i_start      = 1'b0;
    chk("val_drop_after_xfer", u_if.out_val, 0);
    chk("idle_after_xfer", o_busy, 0);
    chk("bit_kept_after_xfer", u_if.out_bit, b0);
`ifdef DISAGREE_CNT_EN
    if (!((v.s == 3'b000) || (v.s == 3'b111)) && err_m < 255) err_m++;
    chk("err_cnt", o_err_cnt, err_m);
`endif
  endtask

  initial begin
    vec_t v;
    checks       = 0;
    failures     = 0;
`ifdef DISAGREE_CNT_EN
    err_m        = 0;
`endif
    //            div div' s       dly hs  exp
    tbl[0] = '{0,   0,  3'b101, 0,  0,  1'b1};
    tbl[1] = '{3,   3,  3'b010, 1,  0,  1'b0};
    tbl[2] = '{1,   1,  3'b011, 5,  1,  1'b1};
    tbl[3] = '{2,   0,  3'b110, 0,  0,  1'b1};
    tbl[4] = '{0,   0,  3'b000, 2,  1,  1'b0};
    tbl[5] = '{0,   7,  3'b111, 0,  0,  1'b1};
    tbl[6] = '{255, 1,  3'b001, 1,  0,  1'b0};
    tbl[7] = '{5,   5,  3'b100, 3,  1,  1'b0};
    tbl[8] = '{1,   4,  3'b101, 2,  0,  1'b1};

    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_div        = 8'd0;
    i_sig_in     = 1'b0;
    u_if.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_out_val", u_if.out_val, 0);
    chk("reset_out_bit", u_if.out_bit, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy_ignored", o_busy, 0);

    for (int i = 0; i < 9; i++) run_vote(tbl[i]);

    // Asynchronous reset in the middle of WAIT; out_bit is 1 from the last vote.
    i_div   = 8'd3;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_out_val", u_if.out_val, 0);
    chk("async_rst_out_bit", u_if.out_bit, 0);
    #2 rst_n = 1'b1;
`ifdef DISAGREE_CNT_EN
    err_m = 0;
    chk("async_rst_err_cnt", o_err_cnt, 0);
`endif
    @(posedge clk); #1;
    v = '{2, 2, 3'b111, 0, 0, 1'b1};
    run_vote(v);

`ifdef DISAGREE_CNT_EN
    for (int i = 0; i < 3; i++) begin
      v = '{0, 0, 3'b011, 0, 0, 1'b1};
      run_vote(v);
    end
    v = '{0, 0, 3'b111, 1, 0, 1'b1};
    run_vote(v);
    chk("err_cnt_three", o_err_cnt, 3);
    for (int i = 0; i < 300; i++) begin
      v.div       = 0;
      v.div_after = 0;
      v.s         = 3'($urandom_range(1, 6));
      v.rdy_delay = 0;
      v.hold_start = 1'b0;
      v.exp       = ($countones(v.s) >= 2);
      run_vote(v);
    end
    chk("err_cnt_saturated", o_err_cnt, 255);
`endif

    if (sb_q.size() != 0) chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
